// File: rtl/mdlu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-fixed in one extra cycle.
module mdlu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_DIV   = 3'd1,
    OP_ZERO  = 3'd2,
    OP_MULTU = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP   = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product upper half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;      // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q, opb_d;    // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_e              op_in;
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod;

  assign op_in     = op_e'(op);
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_sub   = WIDTH'(div_shift - {1'b0, opb_q});
  assign prod      = {acc_q, mq_q};

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          dbz_d   = 1'b0;
          state_d = S_DONE;
          unique case (op_in)
            OP_MULT, OP_MULTU: begin
              acc_d    = '0;
              mq_d     = b_mag;
              opb_d    = a_mag;
              cnt_d    = '0;
              is_div_d = 1'b0;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                // Divide by zero skips the iterations and leaves HI/LO untouched.
                dbz_d   = 1'b1;
                state_d = S_FIX;
              end else begin
                acc_d    = '0;
                mq_d     = a_mag;
                opb_d    = b_mag;
                cnt_d    = '0;
                is_div_d = 1'b1;
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                state_d  = S_RUN;
              end
            end
            OP_ZERO: begin
              hi_d = '0;
              lo_d = '0;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!dbz_q) begin
          if (is_div_q) begin
            lo_d = neg_q  ? -mq_q  : mq_q;
            hi_d = rneg_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    // NOTE: datapath registers are reset too, so an abandoned operation leaves nothing behind.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) && dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/mdlu_iterative.md
Name: mdlu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit. Successor to the single-op combinational MULT/DIV/ZERO multiply-divide path.
- Adds signed and unsigned modes, generic operand width, and a start/busy/done handshake.
- Owns the architectural HI/LO registers.
- Sits beside the ALU. The ALU's MFHI/MFLO selection reads hi/lo directly; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width and width of each of hi/lo; must be >= 4 and even.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state at the next rising edge
- start  in  1  request; accepted only while busy=0
- op  in  3  0 MULT, 1 DIV, 2 ZERO, 3 MULTU, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (no-op)
- a  in  WIDTH  operand A: multiplicand / dividend / MTHI-MTLO source
- b  in  WIDTH  operand B: multiplier / divisor
- busy  out  1  high while an accepted operation is in flight
- done  out  1  one-cycle pulse; hi/lo hold the new result in the same cycle
- div_by_zero  out  1  one-cycle pulse coincident with done for a DIV/DIVU with b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, FSM=IDLE. Reset has priority over every other event, including mid-operation: the operation is abandoned and no done pulse is generated.
- FSM states: IDLE, RUN, FIX, DONE.
- Operand capture: a, b and op are latched at the accepting edge. Later input changes have no effect.
- MULT/MULTU/DIV/DIVU timing:
  - IDLE -> RUN on start.
  - RUN lasts exactly WIDTH cycles, one iteration per cycle.
    - Multiply: shift-add on operand magnitudes.
    - Divide: restoring, one quotient bit per cycle on operand magnitudes.
  - RUN -> FIX: one cycle of sign correction and writeback of hi/lo.
  - FIX -> DONE: done=1 for one cycle, busy=0, hi/lo valid.
  - DONE -> IDLE, or directly accept a new start in the DONE cycle.
  - busy is high for WIDTH+1 cycles (RUN+FIX). Result visible WIDTH+2 cycles after the accepting edge.
- Multiply: full 2*WIDTH product; hi = upper half, lo = lower half. MULT is two's-complement signed; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - DIV truncates toward zero; remainder takes the sign of the dividend.
  - DIVU is unsigned.
  - Overflow case (a = most negative, b = -1): lo = most negative, hi = 0. No flag.
- Divide by zero (b=0 with DIV or DIVU): skip RUN.
  - Accept -> FIX (1 cycle, busy=1) -> DONE with done=1 and div_by_zero=1.
  - hi/lo are unchanged.
- ZERO, MTHI, MTLO: single-cycle operations.
  - At the accepting edge: ZERO clears hi and lo; MTHI sets hi=a; MTLO sets lo=a.
  - done=1 in the next cycle; busy stays 0.
- op=7: treated as accepted; done pulse next cycle, no state change.
- start while busy=1 is ignored entirely: no queueing, no effect on the operation in flight.
- hi/lo change only at writeback or reset; they are stable during RUN.
- done and div_by_zero are never high for more than one consecutive cycle, except for back-to-back single-cycle ops.

Test Plan:
- MULT, WIDTH=32:
  - a=7, b=6 -> busy high 33 cycles; done at cycle 34 after accept; hi=0x00000000, lo=0x0000002A.
  - a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with MULT -> hi=0, lo=1.
- DIV and DIVU:
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 -> lo=14, hi=2.
  - DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV by zero: preload hi=0x1234, lo=0x5678 via MTHI/MTLO; DIV a=9, b=0 -> done and div_by_zero pulse 2 cycles after accept; hi=0x1234, lo=0x5678 unchanged.
- Handshake:
  - Start MULT 7*6, then assert start with DIVU 100/7 at cycles 5 and 20 -> ignored; result still hi=0, lo=42.
  - ZERO issued in the DONE cycle -> accepted; hi=lo=0 next cycle.
- Reset mid-operation: assert reset at RUN cycle 10 of a MULT -> next edge busy=0, hi=lo=0, no done in the following 40 cycles. A new MULT 2*3 then gives lo=6.
